exe_branch_unit: RTL
====================

EXE_BRANCH_UNIT -- requirements
Module: exe_branch_unit

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, number of cycles flush stays asserted after a taken branch; legal range 1..3.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 freeze  input  1  pipeline stall; while 1, all internal state holds.
REQ-005 B  input  1  EXE-stage instruction is a branch (from ID/EX register).
REQ-006 S  input  1  EXE-stage instruction updates status.
REQ-007 PC  input  32  EXE-stage PC value (already PC+4 of the branch).
REQ-008 signed_imm_24  input  24  branch offset in words, two's complement.
REQ-009 alu_sr  input  4  NZCV flags produced by ALU this cycle, bit3=N ... bit0=V.
REQ-010 branch_taken  output  1  one-cycle pulse; IF stage loads branch_addr.
REQ-011 branch_addr  output  32  registered branch target.
REQ-012 flush  output  1  flush request to IF/ID and ID/EX registers.
REQ-013 SR  output  4  architectural status register NZCV.
REQ-014 branch_count  output  16  saturating count of taken branches.

Function
REQ-015 FSM states: IDLE, FLUSH; state, flush counter, SR, branch_count, branch_addr, branch_taken all registered.
REQ-016 Accept condition: state==IDLE and B==1 and freeze==0, sampled at rising edge.
REQ-017 On accept: branch_addr <= PC + (sign_extend(signed_imm_24) << 2), 32-bit modulo wrap, carry discarded.
REQ-018 On accept: branch_taken <= 1 for exactly the next cycle; state -> FLUSH; counter <= FLUSH_CYCLES-1.
REQ-019 flush SHALL be 1 in every cycle the state is FLUSH, i.e. FLUSH_CYCLES consecutive cycles starting the cycle after accept (absent freeze).
REQ-020 In FLUSH, freeze==0: counter==0 -> IDLE, else counter decrements; B ignored (squashed slot).
REQ-021 branch_taken SHALL be 0 in all cycles other than the one following an accept; branch_addr holds its last value otherwise.
REQ-022 freeze==1: state, counter, SR, branch_count, branch_addr hold; branch_taken forced 0 next cycle; flush keeps its current value.
REQ-023 Freeze arriving on the branch_taken cycle: pulse is still delivered once, not repeated after freeze releases.
REQ-024 SR <= alu_sr when S==1 and freeze==0 and state==IDLE; otherwise SR holds.
REQ-025 S and B in the same accepted cycle: both SR update and branch accept occur.
REQ-026 branch_count increments by 1 on each accept; at 16'hFFFF it saturates and stays.
REQ-027 Back-to-back: a B present on the first IDLE cycle after FLUSH ends is accepted normally.

Reset
REQ-028 rst==1 at a rising edge: state=IDLE, counter=0, branch_taken=0, branch_addr=0, flush=0, SR=0, branch_count=0.
REQ-029 rst has priority over freeze and over any accept in the same cycle.
REQ-030 rst asserted mid-FLUSH aborts the flush; flush=0 the cycle after reset edge.

Verification
REQ-031 PC=0x0000_0104, imm24=0x000003, B=1 one cycle -> next cycle branch_taken=1, branch_addr=0x0000_0110; flush=1 for 2 cycles; branch_count=1.
REQ-032 PC=0x0000_0010, imm24=0xFFFFFC (-4) -> branch_addr=0x0000_0000; PC=0xFFFF_FFFC, imm24=0x000001 -> branch_addr=0x0000_0000 (wrap).
REQ-033 B=1 held 4 cycles, FLUSH_CYCLES=2 -> accepts at cycles 0 and 3 only; branch_taken at cycles 1 and 4; branch_count=2.
REQ-034 Accept then freeze=1 for 3 cycles during FLUSH -> flush stays 1 through freeze, total flush-high cycles = 2 + 3; single branch_taken pulse.
REQ-035 S=1, alu_sr=4'b1010 in IDLE -> SR=4'b1010; S=1, alu_sr=4'b0101 during FLUSH or freeze -> SR stays 4'b1010.
REQ-036 rst=1 during second FLUSH cycle with branch_count=5 -> next cycle flush=0, SR=0, branch_count=0, state IDLE; branch_count preloaded to 16'hFFFF plus accept -> stays 16'hFFFF.

Source files
------------

// File: rtl/exe_branch_unit.sv
// EXE-stage branch unit: resolves taken branches, computes the registered
// branch target, drives the IF/ID + ID/EX flush window, keeps the NZCV
// status register and a saturating count of taken branches.
module exe_branch_unit #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        B,
    input  logic        S,
    input  logic [31:0] PC,
    input  logic [23:0] signed_imm_24,
    input  logic [3:0]  alu_sr,
    output logic        branch_taken,
    output logic [31:0] branch_addr,
    output logic        flush,
    output logic [3:0]  SR,
    output logic [15:0] branch_count
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    localparam logic [1:0] FLUSH_LAST = 2'(FLUSH_CYCLES - 1);

    logic [0:0]  state;
    logic [1:0]  flush_cnt;
    logic        accept;
    logic        sr_load;
    logic [31:0] target;

    assign accept  = (state == IDLE) && B && !freeze;
    assign sr_load = (state == IDLE) && S && !freeze;

    // Word offset sign-extended and scaled to bytes; sum wraps modulo 2^32.
    assign target = PC + {{6{signed_imm_24[23]}}, signed_imm_24, 2'b00};

    // Flush is a pure function of state, so it naturally holds during freeze.
    assign flush = (state == FLUSH);

    // FSM and flush-window counter; B is ignored while flushing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            flush_cnt <= '0;
        end else if (!freeze) begin
            case (state)
                IDLE: begin
                    if (B) begin
                        state     <= FLUSH;
                        flush_cnt <= FLUSH_LAST;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - 2'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    flush_cnt <= '0;
                end
            endcase
        end
    end

    // Branch target and one-cycle taken pulse; a frozen cycle never re-arms the pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_taken <= 1'b0;
            branch_addr  <= '0;
        end else begin
            branch_taken <= accept;
            if (accept) begin
                branch_addr <= target;
            end
        end
    end

    // Status register loads from the ALU only in unfrozen IDLE cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            SR <= '0;
        end else if (sr_load) begin
            SR <= alu_sr;
        end
    end

    // Saturating taken-branch counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_count <= '0;
        end else if (accept && (branch_count != '1)) begin
            branch_count <= branch_count + 16'd1;
        end
    end

endmodule
